// File: rtl/logic_cfg_pkg.sv
// Shared types and default widths for the LUT configuration loader.
package logic_cfg_pkg;

    localparam int unsigned DEF_WORD_W = 16;
    localparam int unsigned FRAME_BITS = DEF_WORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/cfg_word_deser.sv
// Serial-to-parallel deserializer for one cell frame: WORD_W data bits LSB first,
// then one even-parity bit. word/parity_ok are meaningful while word_done is high.
module cfg_word_deser
    import logic_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat,
    input  logic              bit_in,
    output logic              word_done,
    output logic              parity_ok,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned FW = WORD_W + 1;
    localparam int unsigned CW = $clog2(FW);

    logic [FW-1:0] shift_q;
    logic [CW-1:0] bit_cnt_q;
    logic          parity_q;
    logic          last_beat;
    logic          unused_lsb;

    // Data enters at the MSB and walks down, so after WORD_W beats bit 0 of the word sits at shift_q[1].
    assign last_beat  = (bit_cnt_q == CW'(WORD_W));
    assign word_done  = beat && last_beat;
    assign parity_ok  = ~(parity_q ^ bit_in);
    assign word       = shift_q[FW-1:1];
    assign unused_lsb = shift_q[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
        end else if (beat) begin
            if (last_beat) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
                parity_q  <= 1'b0;
            end else begin
                shift_q   <= {bit_in, shift_q[FW-1:1]};
                bit_cnt_q <= bit_cnt_q + CW'(1);
                parity_q  <= parity_q ^ bit_in;
            end
        end
    end

endmodule

// File: rtl/logic_cfg_loader.sv
// Frame loader: collects NUM_CELLS parity-checked words into a shadow buffer and
// commits them atomically to lFragBitInfo.
module logic_cfg_loader
    import logic_cfg_pkg::*;
#(
    parameter int unsigned NUM_CELLS = 4,
    parameter int unsigned WORD_W    = DEF_WORD_W
) (
    input  logic                          QCK,
    input  logic                          QRT,
    input  logic                          LOAD_START,
    input  logic                          CFG_VALID,
    input  logic                          CFG_DATA,
    output logic                          CFG_READY,
    output logic [NUM_CELLS*WORD_W-1:0]   lFragBitInfo,
    output logic                          CFG_DONE,
    output logic                          CFG_ERR
);

    localparam int unsigned CNT_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned TOTAL_W = NUM_CELLS * WORD_W;

    state_e               state_q, state_nxt;
    logic [CNT_W-1:0]     word_cnt_q;
    logic [TOTAL_W-1:0]   shadow_q;
    logic [TOTAL_W-1:0]   commit_val;
    logic [WORD_W-1:0]    word;
    logic                 word_done, parity_ok, last_cell;
    logic                 accept_c, restart_c, shadow_wr_c, commit_c, err_set_c;

    // A restart request wins over a beat presented in the same cycle.
    assign accept_c  = (state_q == ST_SHIFT) && CFG_VALID && !LOAD_START;
    assign last_cell = (word_cnt_q == CNT_W'(NUM_CELLS - 1));

    cfg_word_deser #(.WORD_W(WORD_W)) u_deser (
        .clk       (QCK),
        .rst       (QRT),
        .clr       (restart_c),
        .beat      (accept_c),
        .bit_in    (CFG_DATA),
        .word_done (word_done),
        .parity_ok (parity_ok),
        .word      (word)
    );

    always_ff @(posedge QCK) begin
        if (QRT) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt   = state_q;
        restart_c   = 1'b0;
        shadow_wr_c = 1'b0;
        commit_c    = 1'b0;
        err_set_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (LOAD_START) begin
                    restart_c = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (LOAD_START) begin
                    restart_c = 1'b1;
                end else if (word_done) begin
                    if (!parity_ok) begin
                        err_set_c = 1'b1;
                        state_nxt = ST_ERROR;
                    end else if (last_cell) begin
                        commit_c  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        shadow_wr_c = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (LOAD_START) begin
                    restart_c = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The final cell goes straight from the deserializer into the commit image.
    always_comb begin
        commit_val = shadow_q;
        commit_val[(NUM_CELLS-1)*WORD_W +: WORD_W] = word;
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            word_cnt_q   <= '0;
            shadow_q     <= '0;
            lFragBitInfo <= '0;
            CFG_DONE     <= 1'b0;
            CFG_ERR      <= 1'b0;
            CFG_READY    <= 1'b0;
        end else begin
            CFG_DONE  <= commit_c;
            CFG_READY <= (state_nxt == ST_SHIFT);
            if (restart_c) begin
                word_cnt_q <= '0;
                shadow_q   <= '0;
                CFG_ERR    <= 1'b0;
            end else if (shadow_wr_c) begin
                for (int k = 0; k < NUM_CELLS; k++) begin
                    if (word_cnt_q == CNT_W'(k)) shadow_q[k*WORD_W +: WORD_W] <= word;
                end
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end else if (commit_c) begin
                lFragBitInfo <= commit_val;
                word_cnt_q   <= '0;
                shadow_q     <= '0;
            end else if (err_set_c) begin
                CFG_ERR    <= 1'b1;
                word_cnt_q <= '0;
                shadow_q   <= '0;
            end
        end
    end

endmodule

// File: doc/logic_cfg_loader.md
LOGIC_CFG_LOADER -- requirements
Module: logic_cfg_loader

Interface
REQ-001 The block SHALL have exactly one clock, QCK, and one reset, QRT, which is synchronous and active-high.
REQ-002 Parameter NUM_CELLS, default 4: number of logic cells loaded per frame (legal range 1..64).
REQ-003 Parameter WORD_W, default 16: LUT config word width per cell.
REQ-004 QCK  input  1  rising-edge clock.
REQ-005 QRT  input  1  synchronous active-high reset.
REQ-006 LOAD_START  input  1  one-cycle request to begin or restart a frame load.
REQ-007 CFG_VALID  input  1  serial config bit valid.
REQ-008 CFG_DATA  input  1  serial config bit, LSB first.
REQ-009 CFG_READY  output  1  loader accepts a bit this cycle.
REQ-010 lFragBitInfo  output  NUM_CELLS*WORD_W  committed LUT config; cell k occupies bits [k*WORD_W +: WORD_W].
REQ-011 CFG_DONE  output  1  one-cycle pulse: frame committed.
REQ-012 CFG_ERR  output  1  sticky parity-error flag.

Function
REQ-013 States SHALL be IDLE, SHIFT and ERROR.
REQ-014 Per-cell frame: WORD_W data bits, LSB first, then 1 parity bit; total WORD_W+1 beats; even parity over all WORD_W+1 bits.
REQ-015 A beat SHALL be accepted only on a rising edge where CFG_VALID=1 and CFG_READY=1.
REQ-016 CFG_READY SHALL be 1 in SHIFT and 0 in IDLE and ERROR.
REQ-017 IDLE: LOAD_START=1 -> SHIFT, with the bit counter, the word counter and the shadow words cleared.
REQ-018 SHIFT: each accepted data beat SHALL shift into the word shifter; the bit counter increments, range 0..WORD_W.
REQ-019 SHIFT, accepted parity beat, parity good, word_cnt<NUM_CELLS-1: write the shadow word [word_cnt], word_cnt+1, bit_cnt=0.
REQ-020 SHIFT, accepted parity beat, parity good, word_cnt=NUM_CELLS-1: on the same edge, copy all shadow words into lFragBitInfo, set CFG_DONE=1, go to IDLE.
REQ-021 Latency: lFragBitInfo update and the CFG_DONE pulse SHALL be visible the cycle after the final beat is accepted; CFG_DONE SHALL be high for exactly 1 cycle.
REQ-022 SHIFT, accepted parity beat, parity bad: go to ERROR, set CFG_ERR=1, discard the shadow words, leave lFragBitInfo unchanged.
REQ-023 ERROR: CFG_ERR SHALL hold at 1; LOAD_START=1 -> SHIFT with CFG_ERR cleared and the counters cleared.
REQ-024 LOAD_START=1 in SHIFT SHALL restart the frame: counters and shadow words cleared; a simultaneously valid beat is dropped; lFragBitInfo is unchanged.
REQ-025 lFragBitInfo SHALL change only on a successful commit; a partial frame SHALL never be visible.
REQ-026 CFG_VALID in IDLE or ERROR SHALL be ignored, with no state change.
REQ-027 Word-counter wrap SHALL be impossible: the commit at NUM_CELLS-1 returns to IDLE before the counter can increment further.

Reset
REQ-028 While QRT=1 at a rising edge: state=IDLE, lFragBitInfo=0, CFG_DONE=0, CFG_ERR=0, CFG_READY=0, counters=0, shadow=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; reset SHALL take priority over LOAD_START and accepted beats on the same edge.

Structure
REQ-030 A shared package logic_cfg_pkg SHALL hold the state enum, WORD_W default, and FRAME_BITS=WORD_W+1.
REQ-031 Sub-module cfg_word_deser SHALL contain:
  - the (WORD_W+1)-bit shifter, bit counter, running parity;
  - outputs word_done, parity_ok and word.
REQ-032 The top level SHALL contain the FSM, word counter, shadow array and output register.

Verification (NUM_CELLS=2, WORD_W=16)
REQ-033 Clean load:
  - stimulus: LOAD_START, then words 0xA5A5 (parity 0) and 0x0001 (parity 1), CFG_VALID continuous;
  - required response: lFragBitInfo=0x0001_A5A5 and one CFG_DONE pulse, 1 cycle after beat 34.
REQ-034 Bad parity:
  - stimulus: word 0 = 0x00FF sent with parity 1;
  - required response: CFG_ERR=1, CFG_READY=0, lFragBitInfo keeps its prior value, no CFG_DONE;
  - then LOAD_START plus a clean frame -> CFG_ERR=0 and the new value committed.
REQ-035 Restart:
  - stimulus: LOAD_START asserted after 20 beats, with CFG_VALID=1 in the same cycle;
  - required response: the beat is dropped; a following full clean frame (0x1234, 0x8000) commits exactly 0x8000_1234.
REQ-036 Backpressure gaps:
  - stimulus: CFG_VALID toggled 1/0 every cycle for a clean frame;
  - required response: identical commit value; CFG_DONE 1 cycle after the last accepted beat.
REQ-037 Reset mid-frame:
  - stimulus: QRT=1 for 1 cycle after 10 beats;
  - required response: all outputs 0, state IDLE; later CFG_VALID without LOAD_START -> no change.
